// File: rtl/ft245_rx_packer.sv
// ft245_rx_packer: frames the byte stream from the FT245 sync-FIFO front end
// into host commands for the wishbone master handler.
// Frame layout, every field MSB first:
//   SYNC(1B) CMD(1B) LEN(3B, word count) ADDR(4B) then LEN x 32-bit words.
// The packer emits one command strobe per frame and then a valid/ready
// stream of data words. It also flags dropped bytes and stalled partial frames.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   in_byte/in_valid/in_ready   byte stream in (in_ready is combinational)
//   cmd_stb         one-cycle pulse; cmd, cmd_len and cmd_addr are valid
//   cmd, cmd_len, cmd_addr      header fields, held until the next frame
//   data_valid/data_word/data_ready   word stream out
//   frame_done      pulse when the final word of a frame is accepted
//                   (or together with cmd_stb for an empty frame)
//   err_sync        pulse: a non-SYNC byte was dropped while idle
//   err_timeout     pulse: a partial frame was aborted after TIMEOUT idle cycles
module ft245_rx_packer #(
    parameter logic [7:0]  SYNC_BYTE = 8'hCD,
    parameter int unsigned TIMEOUT   = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        cmd_stb,
    output logic [7:0]  cmd,
    output logic [23:0] cmd_len,
    output logic [31:0] cmd_addr,
    output logic        data_valid,
    output logic [31:0] data_word,
    input  logic        data_ready,
    output logic        frame_done,
    output logic        err_sync,
    output logic        err_timeout
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_LEN  = 3'd2,
        S_ADDR = 3'd3,
        S_DATA = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [23:0]   word_cnt_q, word_cnt_d;
    logic [23:0]   stage_q, stage_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          last_pend_q, last_pend_d;

    logic          cmd_stb_q, cmd_stb_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [23:0]   cmd_len_q, cmd_len_d;
    logic [31:0]   cmd_addr_q, cmd_addr_d;
    logic          data_valid_q, data_valid_d;
    logic [31:0]   data_word_q, data_word_d;
    logic          frame_done_q, frame_done_d;
    logic          err_sync_q, err_sync_d;
    logic          err_timeout_q, err_timeout_d;

    logic xfer, take, stall, tmo_hit, hdr_done, word_load;

    // Handshake qualifiers shared by the next-state and output logic
    assign in_ready  = ~data_valid_q | data_ready;
    assign xfer      = in_valid & in_ready;
    assign take      = data_valid_q & data_ready;
    assign stall     = data_valid_q & ~data_ready;
    // A consumer stall freezes the timer, so it can never cause an abort
    assign tmo_hit   = (state_q != S_IDLE) & ~xfer & ~stall & (timer_q == TMO_LAST);
    assign hdr_done  = xfer & (state_q == S_ADDR) & (byte_cnt_q == 2'd3);
    assign word_load = xfer & (state_q == S_DATA) & (byte_cnt_q == 2'd3);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (tmo_hit) begin
            state_d = S_IDLE;
        end else if (xfer) begin
            case (state_q)
                S_IDLE: if (in_byte == SYNC_BYTE) state_d = S_CMD;
                S_CMD:  state_d = S_LEN;
                S_LEN:  if (byte_cnt_q == 2'd2) state_d = S_ADDR;
                S_ADDR: if (byte_cnt_q == 2'd3) state_d = (cmd_len_q == 24'd0) ? S_IDLE : S_DATA;
                // Leave as soon as the final word is loaded; its acceptance is
                // tracked by last_pend and no byte can pass while it is unread.
                S_DATA: if (byte_cnt_q == 2'd3 && word_cnt_q == 24'd1) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output and datapath next values
    always_comb begin
        byte_cnt_d    = byte_cnt_q;
        word_cnt_d    = word_cnt_q;
        stage_d       = stage_q;
        timer_d       = timer_q;
        last_pend_d   = last_pend_q;
        cmd_d         = cmd_q;
        cmd_len_d     = cmd_len_q;
        cmd_addr_d    = cmd_addr_q;
        data_valid_d  = data_valid_q;
        data_word_d   = data_word_q;
        cmd_stb_d     = 1'b0;
        frame_done_d  = 1'b0;
        err_sync_d    = 1'b0;
        err_timeout_d = 1'b0;

        // Idle-cycle timer for partial frames
        if (state_q == S_IDLE || xfer || tmo_hit) begin
            timer_d = '0;
        end else if (!stall) begin
            timer_d = timer_q + TW'(1);
        end

        if (tmo_hit) begin
            byte_cnt_d    = 2'd0;
            err_timeout_d = 1'b1;
        end else if (xfer) begin
            case (state_q)
                S_IDLE: begin
                    byte_cnt_d = 2'd0;
                    if (in_byte != SYNC_BYTE) err_sync_d = 1'b1;
                end
                S_CMD: begin
                    cmd_d      = in_byte;
                    byte_cnt_d = 2'd0;
                end
                S_LEN: begin
                    cmd_len_d  = {cmd_len_q[15:0], in_byte};
                    byte_cnt_d = (byte_cnt_q == 2'd2) ? 2'd0 : byte_cnt_q + 2'd1;
                end
                S_ADDR: begin
                    cmd_addr_d = {cmd_addr_q[23:0], in_byte};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                end
                S_DATA: begin
                    stage_d    = {stage_q[15:0], in_byte};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                end
                default: byte_cnt_d = 2'd0;
            endcase
        end

        // Header complete: strobe the command, empty frames finish here
        if (hdr_done) begin
            cmd_stb_d  = 1'b1;
            word_cnt_d = cmd_len_q;
            if (cmd_len_q == 24'd0) frame_done_d = 1'b1;
        end

        // Consumer takes the presented word; a load in the same cycle wins
        if (take) begin
            data_valid_d = 1'b0;
            last_pend_d  = 1'b0;
            if (last_pend_q) frame_done_d = 1'b1;
        end

        if (word_load) begin
            data_word_d  = {stage_q, in_byte};
            data_valid_d = 1'b1;
            word_cnt_d   = word_cnt_q - 24'd1;
            if (word_cnt_q == 24'd1) last_pend_d = 1'b1;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q    <= 2'd0;
            word_cnt_q    <= 24'd0;
            stage_q       <= 24'd0;
            timer_q       <= '0;
            last_pend_q   <= 1'b0;
            cmd_stb_q     <= 1'b0;
            cmd_q         <= 8'd0;
            cmd_len_q     <= 24'd0;
            cmd_addr_q    <= 32'd0;
            data_valid_q  <= 1'b0;
            data_word_q   <= 32'd0;
            frame_done_q  <= 1'b0;
            err_sync_q    <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            byte_cnt_q    <= byte_cnt_d;
            word_cnt_q    <= word_cnt_d;
            stage_q       <= stage_d;
            timer_q       <= timer_d;
            last_pend_q   <= last_pend_d;
            cmd_stb_q     <= cmd_stb_d;
            cmd_q         <= cmd_d;
            cmd_len_q     <= cmd_len_d;
            cmd_addr_q    <= cmd_addr_d;
            data_valid_q  <= data_valid_d;
            data_word_q   <= data_word_d;
            frame_done_q  <= frame_done_d;
            err_sync_q    <= err_sync_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign cmd_stb     = cmd_stb_q;
    assign cmd         = cmd_q;
    assign cmd_len     = cmd_len_q;
    assign cmd_addr    = cmd_addr_q;
    assign data_valid  = data_valid_q;
    assign data_word   = data_word_q;
    assign frame_done  = frame_done_q;
    assign err_sync    = err_sync_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_ft245_rx_packer.sv
// Bench for ft245_rx_packer: table of frames plus hand-written stall,
// timeout and mid-frame reset sequences, checked through a scoreboard.
module tb_ft245_rx_packer;

    localparam int unsigned TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic        cmd_stb;
    logic [7:0]  cmd;
    logic [23:0] cmd_len;
    logic [31:0] cmd_addr;
    logic        data_valid;
    logic [31:0] data_word;
    logic        data_ready;
    logic        frame_done;
    logic        err_sync;
    logic        err_timeout;

    always #5 clk = ~clk;

    ft245_rx_packer #(.SYNC_BYTE(8'hCD), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
        .cmd_stb(cmd_stb), .cmd(cmd), .cmd_len(cmd_len), .cmd_addr(cmd_addr),
        .data_valid(data_valid), .data_word(data_word), .data_ready(data_ready),
        .frame_done(frame_done), .err_sync(err_sync), .err_timeout(err_timeout)
    );

    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] len;
        logic [31:0] addr;
    } cmd_t;

    typedef struct {
        int               npre;
        logic [1:0][7:0]  pre;
        logic [7:0]       cmd;
        logic [23:0]      len;
        logic [31:0]      addr;
        logic [2:0][31:0] words;
        int               rmode;
        int               exp_fd;
        int               exp_sync;
    } vec_t;

    int tests = 0;
    int fails = 0;
    int n_fd = 0, n_es = 0, n_et = 0;
    int ready_mode = 0;
    int exp_fd_total = 0, exp_sync_total = 0;
    cmd_t        cmd_q[$];
    logic [31:0] word_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got none expected event", name);
    endtask

    // Scoreboard monitor: sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_stb) begin
                if (cmd_q.size() == 0) begin
                    fail_now("cmd_unexpected");
                end else begin
                    cmd_t e;
                    e = cmd_q.pop_front();
                    chk("cmd_fields", {cmd, cmd_len, cmd_addr}, {e.cmd, e.len, e.addr});
                    chk("fd_with_stb", 64'(frame_done), 64'(e.len == 24'd0));
                end
            end
            if (data_valid && data_ready) begin
                if (word_q.size() == 0) begin
                    fail_now("word_unexpected");
                end else begin
                    logic [31:0] w;
                    w = word_q.pop_front();
                    chk("data_word", 64'(data_word), 64'(w));
                end
            end
            n_fd += int'(frame_done);
            n_es += int'(err_sync);
            n_et += int'(err_timeout);
        end
    end

    // Consumer: 0 = always ready, 1 = random, other = stalled
    initial begin
        data_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       data_ready = 1'b1;
                1:       data_ready = 1'($urandom_range(0, 1));
                default: data_ready = 1'b0;
            endcase
        end
    end

    // Called at posedge+1; returns at posedge+1 after the byte transferred
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_byte  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) fail_now("send_byte_stuck");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [7:0] c, input logic [23:0] len, input logic [31:0] addr);
        send_byte(8'hCD);
        send_byte(c);
        for (int i = 2; i >= 0; i--) send_byte(len[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) send_byte(addr[i*8 +: 8]);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [23:0] len, input logic [31:0] addr,
                              input logic [2:0][31:0] w);
        cmd_t e;
        e.cmd = c; e.len = len; e.addr = addr;
        cmd_q.push_back(e);
        for (int k = 0; k < int'(len); k++) word_q.push_back(w[k]);
        send_hdr(c, len, addr);
        for (int k = 0; k < int'(len); k++)
            for (int i = 3; i >= 0; i--) send_byte(w[k][i*8 +: 8]);
    endtask

    task automatic wait_drain();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((word_q.size() != 0 || data_valid) && n < 500);
        if (n >= 500) fail_now("drain_timeout");
        repeat (3) @(posedge clk);
        #1;
    endtask

    vec_t vecs[5];

    initial begin
        int fd0, es0, et0, first_k;
        cmd_t e;

        vecs[0] = '{npre:0, pre:16'h0, cmd:8'h01, len:24'd0, addr:32'h0000_1000,
                    words:{32'h0, 32'h0, 32'h0}, rmode:0, exp_fd:1, exp_sync:0};
        vecs[1] = '{npre:0, pre:16'h0, cmd:8'h02, len:24'd2, addr:32'h0000_0010,
                    words:{32'h0, 32'h1234_5678, 32'hDEAD_BEEF}, rmode:0, exp_fd:1, exp_sync:0};
        vecs[2] = '{npre:0, pre:16'h0, cmd:8'h5A, len:24'd3, addr:32'h8000_0000,
                    words:{32'hFFFF_FFFF, 32'h0000_00CD, 32'hCDCD_CDCD}, rmode:1, exp_fd:1, exp_sync:0};
        vecs[3] = '{npre:2, pre:{8'h55, 8'h00}, cmd:8'h03, len:24'd0, addr:32'h0,
                    words:{32'h0, 32'h0, 32'h0}, rmode:0, exp_fd:1, exp_sync:2};
        vecs[4] = '{npre:0, pre:16'h0, cmd:8'hFF, len:24'd1, addr:32'hFFFF_FFFF,
                    words:{32'h0, 32'h0, 32'hA5A5_A5A5}, rmode:1, exp_fd:1, exp_sync:0};

        rst_n = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
        #3;
        chk("reset_ctrl", 64'({cmd_stb, frame_done, err_sync, err_timeout, data_valid, in_ready}), 64'(6'b000001));
        chk("reset_fields", {cmd, cmd_len, cmd_addr}, 64'h0);
        chk("reset_word", 64'(data_word), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven frames
        for (int i = 0; i < 5; i++) begin
            fd0 = n_fd; es0 = n_es;
            ready_mode = vecs[i].rmode;
            for (int p = 0; p < vecs[i].npre; p++) send_byte(vecs[i].pre[p]);
            send_frame(vecs[i].cmd, vecs[i].len, vecs[i].addr, vecs[i].words);
            wait_drain();
            chk($sformatf("vec%0d_frame_done", i), 64'(n_fd - fd0), 64'(vecs[i].exp_fd));
            chk($sformatf("vec%0d_err_sync", i), 64'(n_es - es0), 64'(vecs[i].exp_sync));
            exp_fd_total   += vecs[i].exp_fd;
            exp_sync_total += vecs[i].exp_sync;
        end

        // Consumer stall for 20 cycles with the first word presented
        ready_mode = 2;
        e.cmd = 8'h02; e.len = 24'd2; e.addr = 32'h10;
        cmd_q.push_back(e);
        word_q.push_back(32'hDEAD_BEEF);
        word_q.push_back(32'h1234_5678);
        send_hdr(8'h02, 24'd2, 32'h10);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        et0 = n_et;
        fork
            begin
                send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
            end
            begin
                repeat (20) begin
                    @(negedge clk);
                    chk("stall_hold", {in_ready, data_valid, data_word, 30'h0},
                        {1'b0, 1'b1, 32'hDEAD_BEEF, 30'h0});
                end
                chk("stall_no_timeout", 64'(n_et - et0), 64'h0);
                ready_mode = 0;
            end
        join
        wait_drain();
        exp_fd_total++;

        // Partial header followed by silence
        ready_mode = 0;
        et0 = n_et;
        send_byte(8'hCD); send_byte(8'h02); send_byte(8'h00);
        first_k = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (err_timeout && first_k < 0) first_k = k;
        end
        chk("timeout_cycle", 64'(first_k), 64'(TMO + 1));
        chk("timeout_once", 64'(n_et - et0), 64'h1);
        @(posedge clk);
        #1;

        // Frame with a gap one cycle short of the timeout
        e.cmd = 8'h07; e.len = 24'd0; e.addr = 32'h1234_5678;
        cmd_q.push_back(e);
        send_byte(8'hCD); send_byte(8'h07);
        repeat (TMO - 1) @(posedge clk);
        #1;
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        wait_drain();
        exp_fd_total++;
        chk("gap_no_timeout", 64'(n_et - et0), 64'h1);

        // Reset during the second byte of the first data word
        e.cmd = 8'h04; e.len = 24'd1; e.addr = 32'h20;
        cmd_q.push_back(e);
        send_hdr(8'h04, 24'd1, 32'h20);
        send_byte(8'hAA); send_byte(8'hBB);
        rst_n = 1'b0;
        #1;
        chk("midrst_ctrl", 64'({cmd_stb, frame_done, err_sync, err_timeout, data_valid, in_ready}), 64'(6'b000001));
        chk("midrst_fields", {cmd, cmd_len, cmd_addr}, 64'h0);
        chk("midrst_word", 64'(data_word), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(8'h09, 24'd1, 32'h0000_0040, {32'h0, 32'h0, 32'h0BAD_F00D});
        wait_drain();
        exp_fd_total++;

        chk("cmd_q_empty", 64'(cmd_q.size()), 64'h0);
        chk("word_q_empty", 64'(word_q.size()), 64'h0);
        chk("total_frame_done", 64'(n_fd), 64'(exp_fd_total));
        chk("total_err_sync", 64'(n_es), 64'(exp_sync_total));
        chk("total_err_timeout", 64'(n_et), 64'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
